sdram_arbiter: RTL and testbench

Round-robin arbiter that shares the single internal access interface of the SDRAM controller among NUM_PORTS requesters (e.g. CPU instruction port, data port, video DMA).
It owns the controller-side handshake and muxes one requester onto it at a time.
Before handing the controller to another port, it drains any in-flight read burst by waiting for the controller idle indication.
A per-grant ack quantum prevents one streaming port from starving the others.

---
 rtl/sdram_arbiter.sv | 124 ++++++++++++
 tb/tb_sdram_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter that muxes NUM_PORTS requesters onto the single SDRAM controller port.
// Ownership changes only after the controller reports idle, so trailing read bursts drain safely.
module sdram_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned QUANTUM   = 16
) (
    input  logic                   sdram_clk,
    input  logic                   sdram_rst_n,
    input  logic [NUM_PORTS-1:0]   acc_i,
    input  logic [NUM_PORTS-1:0]   we_i,
    input  logic [32*NUM_PORTS-1:0] adr_i,
    input  logic [16*NUM_PORTS-1:0] dat_i,
    input  logic [2*NUM_PORTS-1:0] sel_i,
    output logic [NUM_PORTS-1:0]   ack_o,
    output logic [15:0]            dat_o,
    output logic [31:0]            adr_o,
    output logic                   ctrl_acc_o,
    output logic                   ctrl_we_o,
    output logic [31:0]            ctrl_adr_o,
    output logic [15:0]            ctrl_dat_o,
    output logic [1:0]             ctrl_sel_o,
    input  logic                   ctrl_ack_i,
    input  logic [15:0]            ctrl_dat_i,
    input  logic [31:0]            ctrl_adr_i,
    input  logic                   ctrl_idle_i
);
    localparam int unsigned PW    = $clog2(NUM_PORTS);
    localparam logic [7:0]  QUANT = 8'(QUANTUM);

    typedef enum logic [1:0] {StIdle, StGranted, StDrain} state_e;

    state_e               r_state, w_state;
    logic [PW-1:0]        r_owner, w_owner;
    logic [PW-1:0]        r_last, w_last;
    logic [PW-1:0]        w_pick, w_idx;
    logic [7:0]           r_ack_cnt, w_ack_cnt;
    logic [NUM_PORTS-1:0] w_owner_oh;
    logic                 w_granted;
    logic                 w_quota_hit;

    assign w_owner_oh  = NUM_PORTS'(1) << r_owner;
    assign w_granted   = (r_state == StGranted);
    // Quota only bites when someone else is actually waiting.
    assign w_quota_hit = (r_ack_cnt >= QUANT) && (|(acc_i & ~w_owner_oh));
    assign ctrl_acc_o  = w_granted & acc_i[r_owner] & ~w_quota_hit;
    assign ack_o       = ((r_state != StIdle) && ctrl_ack_i) ? w_owner_oh : '0;
    assign dat_o       = ctrl_dat_i;
    assign adr_o       = ctrl_adr_i;

    always_comb begin
        ctrl_we_o  = 1'b0;
        ctrl_adr_o = '0;
        ctrl_dat_o = '0;
        ctrl_sel_o = '0;
        if (w_granted) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (r_owner == PW'(p)) begin
                    ctrl_we_o  = we_i[p];
                    ctrl_adr_o = adr_i[32*p +: 32];
                    ctrl_dat_o = dat_i[16*p +: 16];
                    ctrl_sel_o = sel_i[2*p +: 2];
                end
            end
        end
    end

    // Scan from farthest to nearest so the nearest requester after r_last wins.
    always_comb begin
        w_pick = r_owner;
        w_idx  = '0;
        for (int unsigned i = NUM_PORTS; i >= 1; i--) begin
            w_idx = PW'((32'(r_last) + i) % NUM_PORTS);
            if (acc_i[w_idx]) begin
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_owner   = r_owner;
        w_last    = r_last;
        w_ack_cnt = r_ack_cnt;
        unique case (r_state)
            StIdle: begin
                if (|acc_i) begin
                    w_owner   = w_pick;
                    w_ack_cnt = '0;
                    w_state   = StGranted;
                end
            end
            StGranted: begin
                if (ctrl_ack_i && (r_ack_cnt < QUANT)) begin
                    w_ack_cnt = r_ack_cnt + 8'd1;
                end
                if (!acc_i[r_owner] || w_quota_hit) begin
                    w_last  = r_owner;
                    w_state = StDrain;
                end
            end
            StDrain: begin
                if (ctrl_idle_i) begin
                    w_state = StIdle;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (!sdram_rst_n) begin
            r_state   <= StIdle;
            r_owner   <= '0;
            r_last    <= PW'(NUM_PORTS - 1);
            r_ack_cnt <= '0;
        end else begin
            r_state   <= w_state;
            r_owner   <= w_owner;
            r_last    <= w_last;
            r_ack_cnt <= w_ack_cnt;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural round-robin model.
module tb_sdram_arbiter;
    localparam int N = 4;
    localparam int Q = 4;
    localparam int PH_IDLE  = 0;
    localparam int PH_GRANT = 1;
    localparam int PH_DRAIN = 2;

    logic            sdram_clk   = 1'b0;
    logic            sdram_rst_n = 1'b0;
    logic [N-1:0]    acc_i       = '0;
    logic [N-1:0]    we_i        = '0;
    logic [32*N-1:0] adr_i       = '0;
    logic [16*N-1:0] dat_i       = '0;
    logic [2*N-1:0]  sel_i       = '0;
    logic            ctrl_ack_i  = 1'b0;
    logic [15:0]     ctrl_dat_i  = '0;
    logic [31:0]     ctrl_adr_i  = '0;
    logic            ctrl_idle_i = 1'b0;
    logic [N-1:0]    ack_o;
    logic [15:0]     dat_o;
    logic [31:0]     adr_o;
    logic            ctrl_acc_o;
    logic            ctrl_we_o;
    logic [31:0]     ctrl_adr_o;
    logic [15:0]     ctrl_dat_o;
    logic [1:0]      ctrl_sel_o;

    sdram_arbiter #(
        .NUM_PORTS(N),
        .QUANTUM  (Q)
    ) dut (
        .sdram_clk  (sdram_clk),
        .sdram_rst_n(sdram_rst_n),
        .acc_i      (acc_i),
        .we_i       (we_i),
        .adr_i      (adr_i),
        .dat_i      (dat_i),
        .sel_i      (sel_i),
        .ack_o      (ack_o),
        .dat_o      (dat_o),
        .adr_o      (adr_o),
        .ctrl_acc_o (ctrl_acc_o),
        .ctrl_we_o  (ctrl_we_o),
        .ctrl_adr_o (ctrl_adr_o),
        .ctrl_dat_o (ctrl_dat_o),
        .ctrl_sel_o (ctrl_sel_o),
        .ctrl_ack_i (ctrl_ack_i),
        .ctrl_dat_i (ctrl_dat_i),
        .ctrl_adr_i (ctrl_adr_i),
        .ctrl_idle_i(ctrl_idle_i)
    );

    always #5 sdram_clk = ~sdram_clk;

    int total = 0;
    int bad   = 0;
    int n_ack1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the controller, who was served last, acks this grant.
    int m_phase, m_owner, m_last, m_cnt;
    bit m_valid = 1'b0;

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    function automatic bit quota_hit_f(input logic [N-1:0] req, input int owner, input int cnt);
        return (cnt >= Q) && ((req & ~(N'(1) << owner)) != '0);
    endfunction

    always @(posedge sdram_clk) begin
        if (!sdram_rst_n) begin
            m_phase <= PH_IDLE;
            m_owner <= 0;
            m_last  <= N - 1;
            m_cnt   <= 0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (m_phase == PH_IDLE) begin
                if (acc_i != '0) begin
                    m_owner <= rr_pick(acc_i, m_last);
                    m_cnt   <= 0;
                    m_phase <= PH_GRANT;
                end
            end else if (m_phase == PH_GRANT) begin
                if (ctrl_ack_i && m_cnt < Q) m_cnt <= m_cnt + 1;
                if (!acc_i[m_owner] || quota_hit_f(acc_i, m_owner, m_cnt)) begin
                    m_last  <= m_owner;
                    m_phase <= PH_DRAIN;
                end
            end else if (ctrl_idle_i) begin
                m_phase <= PH_IDLE;
            end
        end
    end

    always @(negedge sdram_clk) begin
        if (m_valid) begin
            chk("ack_o", ack_o,
                (m_phase != PH_IDLE && ctrl_ack_i) ? 64'(N'(1) << m_owner) : 64'd0);
            chk("ctrl_acc_o", ctrl_acc_o, 64'(m_phase == PH_GRANT && acc_i[m_owner]
                && !quota_hit_f(acc_i, m_owner, m_cnt)));
            chk("ctrl_we_o", ctrl_we_o, (m_phase == PH_GRANT) ? 64'(we_i[m_owner]) : 64'd0);
            chk("ctrl_adr_o", ctrl_adr_o,
                (m_phase == PH_GRANT) ? 64'(adr_i[m_owner*32 +: 32]) : 64'd0);
            chk("ctrl_dat_o", ctrl_dat_o,
                (m_phase == PH_GRANT) ? 64'(dat_i[m_owner*16 +: 16]) : 64'd0);
            chk("ctrl_sel_o", ctrl_sel_o,
                (m_phase == PH_GRANT) ? 64'(sel_i[m_owner*2 +: 2]) : 64'd0);
            chk("dat_o", dat_o, 64'(ctrl_dat_i));
            chk("adr_o", adr_o, 64'(ctrl_adr_i));
        end
    end

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic look();
        @(negedge sdram_clk);
    endtask

    task automatic set_port(input int p, input logic we, input logic [31:0] adr,
                            input logic [15:0] dat, input logic [1:0] sel);
        we_i[p]          = we;
        adr_i[32*p +: 32] = adr;
        dat_i[16*p +: 16] = dat;
        sel_i[2*p +: 2]   = sel;
    endtask

    initial begin
        // Reset with every input busy: grant-gated outputs must stay quiet.
        acc_i      = '1;
        adr_i      = {N{32'hA5A5_0000}};
        we_i       = '1;
        ctrl_ack_i = 1'b1;
        tick();
        look();
        chk("rst_ack", ack_o, 0);
        chk("rst_acc", ctrl_acc_o, 0);
        chk("rst_adr", ctrl_adr_o, 0);
        chk("rst_we", ctrl_we_o, 0);

        // Single-port write from port 2.
        tick();
        sdram_rst_n = 1'b1;
        acc_i = '0; we_i = '0; adr_i = '0; ctrl_ack_i = 1'b0;
        set_port(2, 1'b1, 32'h0000_1000, 16'hBEEF, 2'b11);
        acc_i = 4'b0100;
        look();
        chk("t1_idle_acc", ctrl_acc_o, 0);
        tick();
        ctrl_ack_i = 1'b1;
        look();
        chk("t1_acc", ctrl_acc_o, 1);
        chk("t1_adr", ctrl_adr_o, 32'h0000_1000);
        chk("t1_dat", ctrl_dat_o, 16'hBEEF);
        chk("t1_sel", ctrl_sel_o, 2'b11);
        chk("t1_we", ctrl_we_o, 1);
        chk("t1_ack", ack_o, 4'b0100);
        tick();
        ctrl_ack_i = 1'b0;
        acc_i = '0;
        look();
        chk("t1_rel_acc", ctrl_acc_o, 0);
        chk("t1_rel_ack", ack_o, 0);
        tick();
        ctrl_idle_i = 1'b1;
        look();
        chk("t1_drain_acc", ctrl_acc_o, 0);
        tick();
        ctrl_idle_i = 1'b0;
        sdram_rst_n = 1'b0;

        // Ports 0 and 3 together right after reset: port 0 first, then port 3.
        tick();
        sdram_rst_n = 1'b1;
        set_port(0, 1'b1, 32'h0000_0100, 16'h1111, 2'b01);
        set_port(3, 1'b1, 32'h0000_0300, 16'h3333, 2'b10);
        acc_i = 4'b1001;
        tick();
        ctrl_ack_i = 1'b1;
        look();
        chk("t2_adr0", ctrl_adr_o, 32'h0000_0100);
        chk("t2_ack0", ack_o, 4'b0001);
        tick();
        ctrl_ack_i = 1'b0;
        acc_i = 4'b1000;
        look();
        chk("t2_rel_acc", ctrl_acc_o, 0);
        tick();
        ctrl_idle_i = 1'b1;
        tick();
        ctrl_idle_i = 1'b0;
        look();
        chk("t2_idle_acc", ctrl_acc_o, 0);
        tick();
        look();
        chk("t2_acc3", ctrl_acc_o, 1);
        chk("t2_adr3", ctrl_adr_o, 32'h0000_0300);

        // Owner 3 releases while ports 0 and 1 wait: wrap picks port 0.
        tick();
        set_port(1, 1'b1, 32'h0000_0110, 16'h2222, 2'b11);
        acc_i = 4'b0011;
        look();
        chk("t3_rel_acc", ctrl_acc_o, 0);
        tick();
        ctrl_idle_i = 1'b1;
        tick();
        ctrl_idle_i = 1'b0;
        tick();
        look();
        chk("t3_acc", ctrl_acc_o, 1);
        chk("t3_adr", ctrl_adr_o, 32'h0000_0100);
        tick();
        acc_i = '0;
        tick();
        ctrl_idle_i = 1'b1;
        tick();
        ctrl_idle_i = 1'b0;

        // Port 1 read burst of 8 words drains before port 0 gets the controller.
        set_port(1, 1'b0, 32'h0000_2000, 16'h0000, 2'b11);
        acc_i  = 4'b0010;
        n_ack1 = 0;
        tick();
        ctrl_ack_i = 1'b1;
        acc_i = 4'b0011;
        look();
        if (ack_o == 4'b0010) n_ack1++;
        chk("t4_first_acc", ctrl_acc_o, 1);
        for (int k = 0; k < 7; k++) begin
            tick();
            acc_i = 4'b0001;
            look();
            if (ack_o == 4'b0010) n_ack1++;
            chk("t4_drain_acc", ctrl_acc_o, 0);
        end
        tick();
        ctrl_ack_i  = 1'b0;
        ctrl_idle_i = 1'b1;
        look();
        chk("t4_idle_acc", ctrl_acc_o, 0);
        chk("t4_ack_count", n_ack1, 8);
        tick();
        ctrl_idle_i = 1'b0;
        look();
        chk("t4_arb_acc", ctrl_acc_o, 0);

        // Port 0 streams while port 1 waits: quota of 4 acks forces a handover.
        tick();
        acc_i = 4'b0011;
        ctrl_ack_i = 1'b1;
        look();
        chk("t4_grant0_acc", ctrl_acc_o, 1);
        chk("t4_grant0_adr", ctrl_adr_o, 32'h0000_0100);
        for (int k = 0; k < 3; k++) begin
            tick();
            look();
            chk("t5_stream_acc", ctrl_acc_o, 1);
        end
        tick();
        ctrl_ack_i = 1'b0;
        look();
        chk("t5_quota_acc", ctrl_acc_o, 0);
        tick();
        ctrl_idle_i = 1'b1;
        tick();
        ctrl_idle_i = 1'b0;
        tick();
        look();
        chk("t5_p1_acc", ctrl_acc_o, 1);
        chk("t5_p1_adr", ctrl_adr_o, 32'h0000_2000);
        tick();
        acc_i = 4'b0001;
        tick();
        ctrl_idle_i = 1'b1;
        tick();
        ctrl_idle_i = 1'b0;
        tick();
        look();
        chk("t5_regrant_acc", ctrl_acc_o, 1);
        chk("t5_regrant_adr", ctrl_adr_o, 32'h0000_0100);

        // Reset in the middle of a read burst.
        tick();
        we_i[0] = 1'b0;
        ctrl_ack_i = 1'b1;
        sdram_rst_n = 1'b0;
        look();
        chk("t6_pre_ack", ack_o, 4'b0001);
        tick();
        sdram_rst_n = 1'b1;
        acc_i = 4'b1001;
        look();
        chk("t6_ack", ack_o, 0);
        chk("t6_acc", ctrl_acc_o, 0);
        tick();
        ctrl_ack_i = 1'b0;
        look();
        chk("t6_last_pick", ctrl_adr_o, 32'h0000_0100);
        tick();
        acc_i = '0;
        ctrl_idle_i = 1'b1;
        tick();
        tick();

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int c = 0; c < 4000; c++) begin
            tick();
            sdram_rst_n = ($urandom_range(0, 299) != 0);
            for (int p = 0; p < N; p++) begin
                if (!acc_i[p]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_port(p, 1'($urandom), $urandom, 16'($urandom), 2'($urandom));
                        acc_i[p] = 1'b1;
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    acc_i[p] = 1'b0;
                end
            end
            ctrl_ack_i  = 1'($urandom_range(0, 1));
            ctrl_idle_i = ($urandom_range(0, 2) == 0);
            ctrl_dat_i  = 16'($urandom);
            ctrl_adr_i  = $urandom;
        end
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
